// File: rtl/spi_flash_reader.sv
// spi_flash_reader: runs a flash READ burst through a register-mapped SPI peripheral and streams the payload out
module spi_flash_reader #(
    parameter logic [7:0] READ_CMD = 8'h03,
    parameter logic [7:0] FILL     = 8'hFF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [7:0]  len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        spi_ren,
    output logic [2:0]  spi_raddr,
    input  logic [7:0]  spi_rdata,
    output logic        spi_wen,
    output logic [2:0]  spi_waddr,
    output logic [7:0]  spi_wdata
);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] CS_ON  = 4'd1;
    localparam logic [3:0] TX     = 4'd2;
    localparam logic [3:0] GAP    = 4'd3;
    localparam logic [3:0] POLL   = 4'd4;
    localparam logic [3:0] RD     = 4'd5;
    localparam logic [3:0] CAP    = 4'd6;
    localparam logic [3:0] OUT    = 4'd7;
    localparam logic [3:0] CS_OFF = 4'd8;
    localparam logic [3:0] FIN    = 4'd9;

    logic [3:0]  state;
    logic [23:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  idx;
    logic [2:0]  hdr;
    logic        poll_pend;
    logic [7:0]  tx_byte;

    // Burst sequencer; hdr 0..3 are the header bytes, hdr 4 means payload FILL transfers.
    // poll_pend marks that spi_rdata now carries a STATUS read issued last cycle.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            addr_q    <= 24'd0;
            len_q     <= 8'd0;
            idx       <= 8'd0;
            hdr       <= 3'd0;
            poll_pend <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            poll_pend <= state == POLL;
            case (state)
                IDLE: if (start) begin
                    addr_q <= addr;
                    len_q  <= len;
                    idx    <= 8'd0;
                    state  <= CS_ON;
                end
                CS_ON: begin
                    hdr   <= 3'd0;
                    state <= TX;
                end
                TX:  state <= GAP;
                GAP: state <= POLL;
                POLL: if (poll_pend && !spi_rdata[0]) begin
                    if (hdr < 3'd4) begin
                        hdr   <= hdr + 3'd1;
                        state <= TX;
                    end else begin
                        state <= RD;
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    out_data  <= spi_rdata;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    idx       <= idx + 8'd1;
                    state     <= (idx == len_q - 8'd1) ? CS_OFF : TX;
                end
                CS_OFF:  state <= FIN;
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs and register-bus strobes decoded straight from the state.
    always_comb begin
        busy      = state != IDLE;
        done      = state == FIN;
        tx_byte   = hdr == 3'd0 ? READ_CMD :
                    hdr == 3'd1 ? addr_q[23:16] :
                    hdr == 3'd2 ? addr_q[15:8] :
                    hdr == 3'd3 ? addr_q[7:0] : FILL;
        spi_ren   = state == POLL || state == RD;
        spi_raddr = state == POLL ? 3'd1 : 3'd0;
        spi_wen   = state == CS_ON || state == TX || state == CS_OFF;
        spi_waddr = state == TX ? 3'd0 : 3'd2;
        spi_wdata = state == CS_ON ? 8'h01 : state == CS_OFF ? 8'h00 : tx_byte;
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: scoreboard bench driving spi_flash_reader against a simple SPI register model
module tb_spi_flash_reader;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [23:0] addr = 24'd0;
    logic [7:0]  len = 8'd0;
    logic        busy, done, out_valid, spi_ren, spi_wen;
    logic [7:0]  out_data, spi_wdata;
    logic        out_ready = 1'b1;
    logic [2:0]  spi_raddr, spi_waddr;
    logic [7:0]  spi_rdata;

    int checks = 0;
    int failures = 0;

    spi_flash_reader dut (
        .clk(clk), .n_rst(n_rst), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .spi_ren(spi_ren), .spi_raddr(spi_raddr),
        .spi_rdata(spi_rdata), .spi_wen(spi_wen), .spi_waddr(spi_waddr),
        .spi_wdata(spi_wdata)
    );

    always #5 clk = ~clk;

    // SPI peripheral model: DATA write starts a transfer busy for busy_cyc cycles.
    int         busy_cyc = 3;
    int         m_cnt, m_xcnt;
    logic [7:0] m_rx, m_pend;
    logic       m_cs;

    function automatic logic [7:0] miso(int k);
        return 8'(k * 37 + 90);
    endfunction

    always @(posedge clk) begin
        if (!n_rst) begin
            m_cnt <= 0; m_xcnt <= 0; m_rx <= 8'h00; m_pend <= 8'h00; m_cs <= 1'b0; spi_rdata <= 8'h00;
        end else begin
            if (spi_ren)
                spi_rdata <= spi_raddr == 3'd0 ? m_rx : spi_raddr == 3'd1 ? {7'd0, m_cnt != 0} : {7'd0, m_cs};
            if (spi_wen && spi_waddr == 3'd2) begin
                m_cs <= spi_wdata[0];
                m_xcnt <= 0;
            end
            if (spi_wen && spi_waddr == 3'd0) begin
                if (busy_cyc == 0) m_rx <= miso(m_xcnt);
                else begin m_pend <= miso(m_xcnt); m_cnt <= busy_cyc; end
                m_xcnt <= m_xcnt + 1;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_rx <= m_pend;
            end
        end
    end

    logic [10:0] exp_w[$];
    logic [7:0]  exp_d[$];
    int          exp_n[$];
    int          hs_cnt = 0, done_cnt = 0, dcnt = 0;
    logic        done_prev = 1'b0, hold_ok = 1'b0;
    logic [7:0]  hold_v;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes, hands over a byte or finishes.
    always @(negedge clk) begin
        if (!n_rst) begin
            done_prev = 1'b0;
            hold_ok = 1'b0;
        end else begin
            if (spi_wen || spi_ren) chk("strobe_excl", int'(spi_wen && spi_ren), 0);
            if (spi_wen) begin
                if (exp_w.size() == 0) chk("write_unexpected", int'({spi_waddr, spi_wdata}), 0);
                else chk("write", int'({spi_waddr, spi_wdata}), int'(exp_w.pop_front()));
                chk("write_during_hold", int'(out_valid), 0);
                if (spi_waddr == 3'd2) dcnt = 0;
                else if (spi_waddr == 3'd0) dcnt++;
            end
            if (out_valid && !out_ready) begin
                if (hold_ok) chk("hold_stable", out_data, hold_v);
                hold_v = out_data;
                hold_ok = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) chk("payload_unexpected", out_data, -1);
                else chk("payload", out_data, exp_d.pop_front());
                hs_cnt++;
                hold_ok = 1'b0;
            end
            if (done_prev) chk("busy_after_done", busy, 0);
            done_prev = done;
            if (done) begin
                done_cnt++;
                if (exp_n.size() == 0) chk("done_unexpected", 1, 0);
                else chk("handshakes", hs_cnt, exp_n.pop_front());
                hs_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(logic [23:0] a, logic [7:0] l);
        int n = (l == 8'd0) ? 256 : int'(l);
        exp_w.push_back({3'd2, 8'h01});
        exp_w.push_back({3'd0, 8'h03});
        exp_w.push_back({3'd0, a[23:16]});
        exp_w.push_back({3'd0, a[15:8]});
        exp_w.push_back({3'd0, a[7:0]});
        for (int j = 0; j < n; j++) begin
            exp_w.push_back({3'd0, 8'hFF});
            exp_d.push_back(miso(4 + j));
        end
        exp_w.push_back({3'd2, 8'h00});
        exp_n.push_back(n);
    endtask

    task automatic start_burst(logic [23:0] a, logic [7:0] l);
        push_burst(a, l);
        addr = a;
        len = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int limit);
        int d0 = done_cnt;
        for (int i = 0; i < limit && done_cnt == d0; i++) tick();
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        repeat (4) tick();
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ren", spi_ren, 0);
        chk("rst_wen", spi_wen, 0);
        chk("rst_data", out_data, 0);

        n_rst = 1'b1;
        start_burst(24'h123456, 8'd1);
        chk("busy_rise", busy, 1);
        wait_done(500);

        start_burst(24'hABCDEF, 8'd3);
        for (int i = 0; i < 500 && hs_cnt < 1; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 500 && !out_valid; i++) tick();
        chk("stall_valid", out_valid, 1);
        repeat (10) tick();
        out_ready = 1'b1;
        wait_done(500);

        start_burst(24'h000F00, 8'd2);
        repeat (3) tick();
        addr = 24'hFFFFFF;
        len = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(500);

        busy_cyc = 1;
        start_burst(24'h3C5A96, 8'd0);
        wait_done(20000);

        busy_cyc = 0;
        start_burst(24'h010203, 8'd2);
        wait_done(500);

        busy_cyc = 2;
        start_burst(24'h55AA33, 8'd4);
        for (int i = 0; i < 500 && !(spi_ren && spi_raddr == 3'd1 && dcnt == 3); i++) tick();
        chk("reached_poll_hdr2", int'(spi_ren && spi_raddr == 3'd1 && dcnt == 3), 1);
        n_rst = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_ren", spi_ren, 0);
        chk("abort_wen", spi_wen, 0);
        chk("abort_valid", out_valid, 0);
        exp_w.delete();
        exp_d.delete();
        exp_n.delete();
        hs_cnt = 0;
        n_rst = 1'b1;
        start_burst(24'h0A0B0C, 8'd2);
        wait_done(500);

        chk("writes_left", exp_w.size(), 0);
        chk("bytes_left", exp_d.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
